// File: rtl/combo_lock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// combo_lock_pkg: shared state encoding and helpers for param_combo_lock | Rev 1.0
// ---------------------------------------------------------------------------
package combo_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_ALARM    = 2'd3
    } lock_state_t;

    localparam int MAX_CODE_BITS = 256;

    function automatic int safe_clog2(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

    // Returns the w-bit digit idx of a packed code, zero-extended to 32 bits.
    function automatic logic [31:0] digit_at(input logic [MAX_CODE_BITS-1:0] code,
                                             input int idx, input int w);
        logic [MAX_CODE_BITS-1:0] t;
        logic [MAX_CODE_BITS-1:0] mask;
        mask = (MAX_CODE_BITS'(1) << w) - MAX_CODE_BITS'(1);
        t    = (code >> (idx * w)) & mask;
        return t[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/combo_down_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// combo_down_timer: loadable down counter; expire flags the edge reaching 0 | Rev 1.0
// ---------------------------------------------------------------------------
module combo_down_timer #(
    parameter int WIDTH    = 4,
    parameter int LOAD_VAL = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(LOAD_VAL);
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = dec && (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/param_combo_lock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// param_combo_lock: parametrised sequential combination lock with retry alarm.
// Optional auto-relock when COMBO_AUTORELOCK_EN is defined.        | Rev 1.0
// ---------------------------------------------------------------------------
module param_combo_lock
    import combo_lock_pkg::*;
#(
    parameter int                         SW_W         = 3,
    parameter int                         CODE_LEN     = 5,
    parameter int                         MAX_TRIES    = 3,
    parameter int                         TIMEOUT      = 8,
    parameter logic [SW_W*CODE_LEN-1:0]   DEFAULT_CODE = 15'h4688,
    parameter int                         RELOCK_CYC   = 16,
    localparam int                        IDX_W        = safe_clog2(CODE_LEN),
    localparam int                        TRY_W        = safe_clog2(MAX_TRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SW_W-1:0]  sw,
    input  logic             sw_valid,
    input  logic             lock_req,
    input  logic             prog,
    output logic             locked,
    output logic             alarm,
    output logic             entimer,
    output logic [IDX_W-1:0] selsw,
    output logic [TRY_W-1:0] tries
);

    localparam int CODE_W  = SW_W * CODE_LEN;
    localparam int TMR_W   = safe_clog2(TIMEOUT + 1);
    localparam int RL_W    = safe_clog2(RELOCK_CYC + 1);

    lock_state_t       state, state_nxt;
    logic [CODE_W-1:0] code, code_nxt;
    logic [CODE_W-1:0] shadow, shadow_nxt;
    logic              locked_nxt, alarm_nxt, entimer_nxt;
    logic [IDX_W-1:0]  selsw_nxt;
    logic [TRY_W-1:0]  tries_nxt;
    logic [SW_W-1:0]   exp_digit;
    logic              ent_load, ent_expire, relock_expire, fail, unlock;

    assign exp_digit = SW_W'(digit_at(MAX_CODE_BITS'(code), int'(selsw), SW_W));

    combo_down_timer #(
        .WIDTH    (TMR_W),
        .LOAD_VAL (TIMEOUT)
    ) u_entry_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (ent_load),
        .dec    (state == ST_ENTRY),
        .expire (ent_expire)
    );

`ifdef COMBO_AUTORELOCK_EN
    // Held loaded outside UNLOCKED so entry starts from a full count.
    combo_down_timer #(
        .WIDTH    (RL_W),
        .LOAD_VAL (RELOCK_CYC)
    ) u_relock_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state != ST_UNLOCKED) || sw_valid),
        .dec    ((state == ST_UNLOCKED) && !sw_valid),
        .expire (relock_expire)
    );
`else
    assign relock_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            code    <= DEFAULT_CODE;
            shadow  <= '0;
            locked  <= 1'b1;
            alarm   <= 1'b0;
            entimer <= 1'b0;
            selsw   <= '0;
            tries   <= '0;
        end else begin
            state   <= state_nxt;
            code    <= code_nxt;
            shadow  <= shadow_nxt;
            locked  <= locked_nxt;
            alarm   <= alarm_nxt;
            entimer <= entimer_nxt;
            selsw   <= selsw_nxt;
            tries   <= tries_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        code_nxt    = code;
        shadow_nxt  = shadow;
        locked_nxt  = locked;
        alarm_nxt   = alarm;
        entimer_nxt = entimer;
        selsw_nxt   = selsw;
        tries_nxt   = tries;
        ent_load    = 1'b0;
        fail        = 1'b0;
        unlock      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sw_valid) begin
                    if (sw == exp_digit) begin
                        if (CODE_LEN == 1) begin
                            unlock = 1'b1;
                        end else begin
                            state_nxt   = ST_ENTRY;
                            entimer_nxt = 1'b1;
                            selsw_nxt   = IDX_W'(1);
                            ent_load    = 1'b1;
                        end
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                // Expiry beats a digit arriving on the same edge.
                if (ent_expire) begin
                    fail = 1'b1;
                end else if (sw_valid) begin
                    if (sw != exp_digit) begin
                        fail = 1'b1;
                    end else if (selsw == IDX_W'(CODE_LEN - 1)) begin
                        unlock = 1'b1;
                    end else begin
                        selsw_nxt = selsw + 1'b1;
                        ent_load  = 1'b1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (lock_req || relock_expire) begin
                    state_nxt  = ST_IDLE;
                    locked_nxt = 1'b1;
                    selsw_nxt  = '0;
                end else if (prog) begin
                    if (sw_valid) begin
                        shadow_nxt[selsw*SW_W +: SW_W] = sw;
                        if (selsw == IDX_W'(CODE_LEN - 1)) begin
                            code_nxt  = shadow_nxt;
                            selsw_nxt = '0;
                        end else begin
                            selsw_nxt = selsw + 1'b1;
                        end
                    end
                end else begin
                    selsw_nxt = '0;
                end
            end
            ST_ALARM: begin
                alarm_nxt  = 1'b1;
                locked_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (unlock) begin
            state_nxt   = ST_UNLOCKED;
            locked_nxt  = 1'b0;
            entimer_nxt = 1'b0;
            selsw_nxt   = '0;
            tries_nxt   = '0;
        end

        if (fail) begin
            selsw_nxt   = '0;
            entimer_nxt = 1'b0;
            if (tries == TRY_W'(MAX_TRIES - 1)) begin
                state_nxt  = ST_ALARM;
                alarm_nxt  = 1'b1;
                locked_nxt = 1'b1;
                tries_nxt  = TRY_W'(MAX_TRIES);
            end else begin
                state_nxt = ST_IDLE;
                tries_nxt = tries + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_combo_lock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_param_combo_lock: scoreboard bench with a behavioural lock model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_param_combo_lock;

    localparam int CODE_LEN  = 5;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] sw = '0;
    logic       sw_valid = 1'b0;
    logic       lock_req = 1'b0;
    logic       prog = 1'b0;
    logic       locked, alarm, entimer;
    logic [2:0] selsw;
    logic [1:0] tries;

    param_combo_lock dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .sw_valid (sw_valid),
        .lock_req (lock_req),
        .prog     (prog),
        .locked   (locked),
        .alarm    (alarm),
        .entimer  (entimer),
        .selsw    (selsw),
        .tries    (tries)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit locked;
        bit alarm;
        bit entimer;
        int selsw;
        int tries;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Model: mode 0=idle 1=entry 2=unlocked 3=alarm
    int m_mode, m_pos, m_elapsed, m_tries, m_pcnt;
    int m_code[CODE_LEN];
    int m_buf[CODE_LEN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("locked",  32'(locked),  32'(e.locked));
            chk("alarm",   32'(alarm),   32'(e.alarm));
            chk("entimer", 32'(entimer), 32'(e.entimer));
            chk("selsw",   32'(selsw),   32'(e.selsw));
            chk("tries",   32'(tries),   32'(e.tries));
        end
    end

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_elapsed = 0; m_tries = 0; m_pcnt = 0;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = i;
    endtask

    task automatic model_unlock();
        m_mode = 2; m_pos = 0; m_tries = 0; m_pcnt = 0;
    endtask

    task automatic model_fail();
        m_tries++;
        m_pos = 0;
        m_mode = (m_tries >= MAX_TRIES) ? 3 : 0;
    endtask

    task automatic model_step(input int s, input bit v, input bit lr, input bit pg);
        case (m_mode)
            0: if (v) begin
                if (s == m_code[0]) begin
                    if (CODE_LEN == 1) model_unlock();
                    else begin m_mode = 1; m_pos = 1; m_elapsed = 0; end
                end else model_fail();
            end
            1: begin
                m_elapsed++;
                if (m_elapsed == TIMEOUT) model_fail();
                else if (v) begin
                    if (s != m_code[m_pos]) model_fail();
                    else begin
                        m_pos++;
                        m_elapsed = 0;
                        if (m_pos == CODE_LEN) model_unlock();
                    end
                end
            end
            2: begin
                if (lr) begin m_mode = 0; m_pcnt = 0; end
                else if (pg) begin
                    if (v) begin
                        m_buf[m_pcnt] = s;
                        m_pcnt++;
                        if (m_pcnt == CODE_LEN) begin
                            m_code = m_buf;
                            m_pcnt = 0;
                        end
                    end
                end else m_pcnt = 0;
            end
            default: ;
        endcase
    endtask

    task automatic step(input int s, input bit v, input bit lr, input bit pg);
        exp_t e;
        @(posedge clk);
        #1;
        sw = 3'(s); sw_valid = v; lock_req = lr; prog = pg;
        model_step(s, v, lr, pg);
        e.cyc     = cyc + 1;
        e.locked  = (m_mode != 2);
        e.alarm   = (m_mode == 3);
        e.entimer = (m_mode == 1);
        e.selsw   = (m_mode == 1) ? m_pos : (m_mode == 2) ? m_pcnt : 0;
        e.tries   = m_tries;
        q.push_back(e);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #7;
        sw = '0; sw_valid = 0; lock_req = 0; prog = 0;
        reset = 1'b0;
        #1;
        chk("rst_locked",  32'(locked),  32'd1);
        chk("rst_alarm",   32'(alarm),   32'd0);
        chk("rst_entimer", 32'(entimer), 32'd0);
        chk("rst_selsw",   32'(selsw),   32'd0);
        chk("rst_tries",   32'(tries),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic enter(input int d0, input int d1, input int d2, input int d3, input int d4);
        step(d0, 1, 0, 0); step(d1, 1, 0, 0); step(d2, 1, 0, 0);
        step(d3, 1, 0, 0); step(d4, 1, 0, 0);
    endtask

    function automatic int hint_digit();
        if (m_mode == 1) return m_code[m_pos];
        return m_code[0];
    endfunction

    initial begin
        bit rpg;
        model_reset();
        do_reset();

        enter(0, 1, 2, 3, 4);                 // default code unlocks
        step(0, 0, 1, 0);                     // relock
        step(0, 1, 0, 0); step(1, 1, 0, 0); step(5, 1, 0, 0);
        enter(0, 1, 2, 3, 4);
        step(0, 0, 1, 0);

        step(7, 1, 0, 0); step(7, 1, 0, 0); step(7, 1, 0, 0);
        enter(0, 1, 2, 3, 4);                 // ignored in alarm
        do_reset();

        step(0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
        step(1, 1, 0, 0);                     // expiry edge beats digit
        do_reset();

        enter(0, 1, 2, 3, 4);
        for (int i = 0; i < CODE_LEN; i++) step(6, 1, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        enter(6, 6, 6, 6, 6);
        step(0, 0, 1, 0);
        enter(0, 1, 2, 3, 4);

        enter(6, 6, 6, 6, 6);
        step(3, 1, 0, 1); step(3, 1, 0, 1);   // partial program then abort
        step(0, 0, 1, 0);
        step(0, 1, 0, 0); step(1, 1, 0, 0); step(2, 1, 0, 0);
        do_reset();
        enter(0, 1, 2, 3, 4);
        step(0, 0, 1, 0);

        rpg = 0;
        for (int n = 0; n < 3000; n++) begin
            int s;
            bit v, lr;
            if (m_mode == 3 && $urandom_range(0, 9) == 0) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 80) == 0) begin
                for (int k = 0; k < TIMEOUT + 1; k++) step(0, 0, 0, rpg);
                continue;
            end
            if (m_mode == 2 && $urandom_range(0, 20) == 0) rpg = !rpg;
            if (m_mode != 2) rpg = 0;
            v  = ($urandom_range(0, 3) != 0);
            lr = (m_mode == 2) && ($urandom_range(0, 25) == 0);
            s  = ($urandom_range(0, 5) != 0 && !rpg) ? hint_digit() : int'($urandom_range(0, 7));
            step(s, v, lr, rpg);
        end

        step(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #7;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_combo_lock.md
Name: param_combo_lock

Overview:
Parametrised sequential combination lock. It is the successor to the fixed 3-bit switch lock, with configurable digit width, code length, retry limit and inter-digit timeout. Digits are entered one per sw_valid strobe. Wrong digits or timeouts count as failed tries, and reaching the retry limit latches the alarm. While unlocked, the code can be reprogrammed at run time. The block sits between the switch/debounce front end and the door actuator and alarm drivers.

Parameters:
SW_W, 3, width of one code digit / switch bus
CODE_LEN, 5, digits per code (>=1)
MAX_TRIES, 3, failed attempts that trigger alarm (>=1)
TIMEOUT, 8, idle cycles allowed between accepted digits (>=1)
DEFAULT_CODE, 15'h4688, reset code; digit i at bits [i*SW_W +: SW_W]; the default value encodes 0,1,2,3,4
RELOCK_CYC, 16, auto-relock idle cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
sw  in  SW_W  digit value, sampled when sw_valid=1
sw_valid  in  1  one-cycle digit strobe
lock_req  in  1  relock request while unlocked
prog  in  1  program mode while unlocked
locked  out  1  1 = door locked
alarm  out  1  latched alarm
entimer  out  1  1 while the entry timer runs (ENTRY state)
selsw  out  IDX_W  index of next expected/programmed digit; IDX_W = max(1, clog2(CODE_LEN))
tries  out  TRY_W  failed-attempt count; TRY_W = clog2(MAX_TRIES+1)

Behaviour:
- All outputs are registered. Inputs are sampled on the rising clk edge, and results are visible after that edge.
- Reset (reset=0), asynchronous and also mid-operation: state=IDLE, locked=1, alarm=0, entimer=0, selsw=0, tries=0, timer=0. The stored code reloads to DEFAULT_CODE, and any pending programming is discarded.
- States: IDLE, ENTRY, UNLOCKED, ALARM.
- IDLE: on sw_valid with sw==code[0]:
  - if CODE_LEN==1, go to UNLOCKED;
  - otherwise go to ENTRY with selsw=1 and timer=TIMEOUT.
  On sw_valid with a wrong digit: failure.
- ENTRY: entimer=1.
  - sw_valid with sw==code[selsw]: selsw+1 and timer reload to TIMEOUT. If that digit was the last (selsw==CODE_LEN-1), go to UNLOCKED with selsw=0, tries=0.
  - sw_valid with a wrong digit: failure.
  - No sw_valid: timer decrements. The edge on which the timer reaches 0 is a failure, i.e. the TIMEOUT-th consecutive idle cycle.
  - Timer expiry on the same edge as a sw_valid: expiry wins and the digit is discarded.
- Failure: tries+1, selsw=0, entimer=0, return to IDLE. The failing digit is not re-evaluated as a first digit. If tries reaches MAX_TRIES, go to ALARM instead.
- UNLOCKED: locked=0, entimer=0.
  - lock_req=1 (prog ignored): go to IDLE with locked=1; any partial program is aborted and the old code is kept.
  - prog=1 with sw_valid: the digit is written to a shadow register at index selsw, and selsw increments. After CODE_LEN digits, the shadow commits atomically to the stored code and selsw=0.
  - prog dropping before completion: shadow discarded, selsw=0.
- ALARM: alarm=1, locked=1. All inputs are ignored, and the state is held until reset.
- tries saturates at MAX_TRIES and never wraps. selsw never exceeds CODE_LEN-1.

Optional Feature:
COMBO_AUTORELOCK_EN.
- Defined: in UNLOCKED, a counter loads RELOCK_CYC on entry and reloads on any sw_valid. On reaching 0, the block returns to IDLE with locked=1. An in-progress program is aborted and the old code is kept. lock_req still works.
- Undefined: the block stays UNLOCKED until lock_req or reset, and RELOCK_CYC is unused.

Decomposition:
- Package combo_lock_pkg: state enum (IDLE, ENTRY, UNLOCKED, ALARM), digit-extract helper function, safe clog2 helper (min 1).
- Sub-module combo_down_timer: loadable down counter with load, dec and expire pulse. It is instantiated for the entry timer and, under COMBO_AUTORELOCK_EN, for the relock counter.

Test Plan:
- Defaults. Reset, then sw=0,1,2,3,4 on consecutive sw_valid cycles -> selsw steps 1,2,3,4 then 0; locked=0 after the 5th edge; tries=0.
- Sequence 0,1,5 -> tries=1, selsw=0, entimer=0, locked=1. Then 0..4 -> unlocks, tries=0.
- Three attempts failing at the first digit (sw=7) -> tries=1,2, then alarm=1. Correct sequence afterwards is ignored (locked=1). reset=0 -> alarm=0, tries=0.
- sw=0 accepted, then 8 idle cycles -> on the 8th idle edge tries=1, state IDLE. Same test with sw_valid=1, sw=1 on that 8th edge -> still a failure.
- Unlock, prog=1 with digits 6,6,6,6,6, prog=0, lock_req -> locked=1. Entering 6,6,6,6,6 -> unlocks; entering 0..4 -> failure on the first digit.
- Reset=0 mid-entry after 0,1,2 -> immediately locked=1, selsw=0, entimer=0. Reprogrammed code reverts to 0..4.
